// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Brief    : Instruction-fetch stage. Holds the PC and assembles each 32-bit
//            little-endian instruction from four byte reads on a shared
//            byte-wide memory port. Stalls the pipeline while a word is
//            incomplete. A branch redirect aborts any in-flight fetch.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk              in   1   clock, rising edge
//   rst              in   1   asynchronous active-high reset
//   stall_i          in   6   pipeline stall vector, bit 0 holds PC/IF
//   branch_flag_i    in   1   redirect request from EX
//   branch_target_i  in  32   redirect target PC
//   mem_grant_i      in   1   arbiter accepts this cycle's byte request
//   mem_din_i        in   8   read byte, valid the cycle after a grant
//   mem_req_o        out  1   byte read request
//   mem_addr_o       out 32   byte address of request
//   stallreq_o       out  1   fetch incomplete, stall the pipeline
//   if_pc_o          out 32   PC of the word in if_inst_o
//   if_inst_o        out 32   assembled instruction
// Optional feature macro: ICACHE_EN (direct-mapped one-word-line cache with
//   ICACHE_LINES lines; undefined = every word fetched from memory).
// ============================================================================
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          ICACHE_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        mem_grant_i,
  input  logic [7:0]  mem_din_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        stallreq_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_DONE  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [2:0]  r_iss;
  logic [2:0]  r_rcv;
  logic        r_inflight;   // a request was granted last cycle; its byte is on mem_din_i now
  logic        r_discard;    // that byte belongs to a fetch aborted by a branch
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_inst;

  logic        w_grant;
  logic        w_byte_ok;
  logic [2:0]  w_iss_nxt;
  logic        w_entry_hit;  // next word (branch target or pc+4) is cached
  logic        w_hit_now;    // current fetch is served from the cache
  logic [31:0] w_hit_word;
  logic        w_unused;

  assign w_grant   = r_mem_req & mem_grant_i;
  assign w_byte_ok = r_inflight & ~r_discard;
  assign w_iss_nxt = r_iss + {2'b00, w_grant};

  // Line count must be a non-zero power of two; this block is empty on
  // purpose and only exists when the parameter is illegal.
  if ((ICACHE_LINES < 1) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_bad_lines
  end

`ifdef ICACHE_EN
  localparam int c_IDX_W = $clog2(ICACHE_LINES);
  localparam int c_TAG_W = 30 - c_IDX_W;

  logic               r_valid [ICACHE_LINES];
  logic [c_TAG_W-1:0] r_tag   [ICACHE_LINES];
  logic [31:0]        r_data  [ICACHE_LINES];
  logic               r_hit;
  logic [31:0]        r_hit_word;
  logic [31:0]        w_entry_pc;
  logic [c_IDX_W-1:0] w_lu_idx;
  logic [c_IDX_W-1:0] w_fill_idx;
  logic               w_fill;
  logic               w_entering;

  assign w_entry_pc  = branch_flag_i ? branch_target_i : (r_pc + 32'd4);
  assign w_lu_idx    = w_entry_pc[c_IDX_W+1:2];
  assign w_fill_idx  = r_pc[c_IDX_W+1:2];
  assign w_entry_hit = r_valid[w_lu_idx] && (r_tag[w_lu_idx] == w_entry_pc[31:c_IDX_W+2]);
  assign w_hit_now   = r_hit;
  assign w_hit_word  = r_hit_word;
  assign w_entering  = branch_flag_i || ((r_state == S_DONE) && !stall_i[0]);
  assign w_fill      = !branch_flag_i && (r_state == S_FETCH) && !r_hit &&
                       w_byte_ok && (r_rcv == 3'd3);

  // Lookup happens in the cycle the next word is chosen, so a hit can be
  // presented at the first edge spent in S_FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit      <= 1'b0;
      r_hit_word <= 32'd0;
      for (int i = 0; i < ICACHE_LINES; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else begin
      r_hit <= 1'b0;
      if (w_entering) begin
        r_hit      <= w_entry_hit;
        r_hit_word <= r_data[w_lu_idx];
      end
      if (w_fill) begin
        r_valid[w_fill_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= r_pc[31:c_IDX_W+2];
      r_data[w_fill_idx] <= {mem_din_i, r_if_inst[23:0]};
    end
  end

  assign w_unused = &{1'b0, stall_i[5:1], w_entry_pc[1:0]};
`else
  assign w_entry_hit = 1'b0;
  assign w_hit_now   = 1'b0;
  assign w_hit_word  = 32'd0;
  assign w_unused    = &{1'b0, stall_i[5:1]};
`endif

  // Request/address are registered one step ahead: every transition also
  // loads the request that the following cycle must present.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_iss      <= 3'd0;
      r_rcv      <= 3'd0;
      r_inflight <= 1'b0;
      r_discard  <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 32'd0;
      r_if_pc    <= RESET_PC;
      r_if_inst  <= 32'd0;
    end else begin
      r_inflight <= w_grant;
      r_discard  <= 1'b0;
      if (branch_flag_i) begin
        r_state    <= S_FETCH;
        r_pc       <= branch_target_i;
        r_iss      <= 3'd0;
        r_rcv      <= 3'd0;
        r_if_inst  <= 32'd0;
        r_discard  <= w_grant;
        r_mem_req  <= ~w_entry_hit;
        r_mem_addr <= branch_target_i;
      end else begin
        case (r_state)
          S_FETCH: begin
            if (w_hit_now) begin
              r_if_inst <= w_hit_word;
              r_if_pc   <= r_pc;
              r_state   <= S_DONE;
              r_mem_req <= 1'b0;
            end else begin
              r_iss <= w_iss_nxt;
              if (w_iss_nxt != 3'd4) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= r_pc + {29'd0, w_iss_nxt};
              end else begin
                r_mem_req <= 1'b0;
              end
              if (w_byte_ok) begin
                r_if_inst[{r_rcv[1:0], 3'b000} +: 8] <= mem_din_i;
                r_rcv <= r_rcv + 3'd1;
                if (r_rcv == 3'd3) begin
                  r_state <= S_DONE;
                  r_if_pc <= r_pc;
                end
              end
            end
          end
          S_DONE: begin
            if (!stall_i[0]) begin
              r_state    <= S_FETCH;
              r_pc       <= r_pc + 32'd4;
              r_iss      <= 3'd0;
              r_rcv      <= 3'd0;
              r_mem_req  <= ~w_entry_hit;
              r_mem_addr <= r_pc + 32'd4;
            end else begin
              r_mem_req <= 1'b0;
            end
          end
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end

  assign stallreq_o = (r_state == S_FETCH);
  assign mem_req_o  = r_mem_req;
  assign mem_addr_o = r_mem_addr;
  assign if_pc_o    = r_if_pc;
  assign if_inst_o  = r_if_inst;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Brief    : Self-checking bench for if_fetch_unit. A word-level reference
//            model (PC, grants taken for the current word, completion delay)
//            predicts every output each cycle; directed scenarios are
//            followed by a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

  localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [5:0]  stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        mem_grant_i;
  logic [7:0]  mem_din_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        stallreq_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;

  if_fetch_unit #(
    .RESET_PC     (c_RESET_PC),
    .ICACHE_LINES (64)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .mem_grant_i     (mem_grant_i),
    .mem_din_i       (mem_din_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .stallreq_o      (stallreq_o),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem_tab [256];

  // Reference model state
  logic [31:0] m_pc;
  int          m_grants;
  bit          m_done;
  bit          m_wait;
  logic [31:0] m_ifpc;
  logic [31:0] m_inst;
  bit          m_inst_known;
  bit          m_dvalid;
  logic [31:0] m_daddr;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return mem_tab[a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24]];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc         = c_RESET_PC;
    m_grants     = 0;
    m_done       = 1'b0;
    m_wait       = 1'b0;
    m_ifpc       = c_RESET_PC;
    m_inst       = 32'd0;
    m_inst_known = 1'b1;
    m_dvalid     = 1'b0;
    m_daddr      = 32'd0;
  endtask

  task automatic check_outputs();
    check("stallreq", {31'd0, stallreq_o}, {31'd0, !m_done});
    if (!m_done) begin
      check("mem_req", {31'd0, mem_req_o}, {31'd0, (m_grants < 4)});
      if (m_grants < 4) check("mem_addr", mem_addr_o, m_pc + 32'(m_grants));
    end else begin
      check("mem_req_done", {31'd0, mem_req_o}, 32'd0);
    end
    check("if_pc", if_pc_o, m_ifpc);
    if (m_inst_known) check("if_inst", if_inst_o, m_inst);
  endtask

  // Advance the model across one rising edge given the inputs of that cycle.
  task automatic model_update(input logic g, input logic b, input logic [31:0] tgt, input logic s);
    bit          req;
    bit          gr;
    logic [31:0] ga;
    bit          keep;
    req  = !m_done && (m_grants < 4);
    gr   = req && g;
    ga   = m_pc + 32'(m_grants);
    keep = m_dvalid;
    if (b) begin
      m_pc = tgt; m_grants = 0; m_done = 0; m_wait = 0;
      m_inst = 32'd0; m_inst_known = 1'b1;
    end else if (m_done) begin
      if (!s) begin m_pc = m_pc + 32'd4; m_grants = 0; m_done = 0; end
    end else begin
      if (m_wait) begin
        m_done = 1; m_wait = 0; m_ifpc = m_pc;
        m_inst = word_at(m_pc); m_inst_known = 1'b1;
      end else if (keep) begin
        m_inst_known = 1'b0;
      end
      if (gr) begin
        m_grants++;
        if (m_grants == 4) m_wait = 1;
      end
    end
    // A byte granted in a branch cycle is still delivered (stale) and must be dropped.
    m_dvalid = gr && !b;
    m_daddr  = ga;
    if (gr && b) m_dvalid = 1'b0;
  endtask

  // Called at a falling edge: check, drive, cross the rising edge, return at next falling edge.
  task automatic step(input logic g, input logic b, input logic [31:0] tgt, input logic s);
    logic [31:0] stale_addr;
    bit          stale;
    check_outputs();
    mem_grant_i     = g;
    branch_flag_i   = b;
    branch_target_i = tgt;
    stall_i         = {5'($urandom), s};
    mem_din_i       = m_dvalid ? mem_byte(m_daddr) : 8'($urandom);
    stale      = !m_done && (m_grants < 4) && g && b;
    stale_addr = m_pc + 32'(m_grants);
    @(posedge clk);
    model_update(g, b, tgt, s);
    @(negedge clk);
    if (stale) mem_din_i = mem_byte(stale_addr);
  endtask

  task automatic check_reset_values();
    check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_if_pc", if_pc_o, c_RESET_PC);
    check("rst_if_inst", if_inst_o, 32'd0);
    check("rst_stallreq", {31'd0, stallreq_o}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_tab[i] = 8'($urandom);
    mem_tab[0] = 8'h13; mem_tab[1] = 8'h00; mem_tab[2] = 8'h00; mem_tab[3] = 8'h00;

    rst = 1'b1; stall_i = 6'd0; branch_flag_i = 1'b0; branch_target_i = 32'd0;
    mem_grant_i = 1'b0; mem_din_i = 8'd0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    @(posedge clk); @(negedge clk);

    // 1: continuous grant, word at 0 completes with stallreq low in cycle 5
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    check("t1_stallreq", {31'd0, stallreq_o}, 32'd0);
    check("t1_inst", if_inst_o, 32'h0000_0013);
    check("t1_pc", if_pc_o, 32'd0);

    // 3: held in S_DONE by stall for 3 cycles, then advance to pc=4
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    check("t3_addr", mem_addr_o, 32'd4);

    // 2: grant low for two cycles during byte 2
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    check("t2_addr_held", mem_addr_o, 32'd6);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("t2_inst", if_inst_o, word_at(32'd4));
    check("t2_pc", if_pc_o, 32'd4);
    step(1'b0, 1'b0, 32'd0, 1'b0);

    // 4: branch to 0x100 in the cycle byte 1 is granted
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b1, 32'h100, 1'b1);
    check("t4_addr", mem_addr_o, 32'h100);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    check("t4_pc", if_pc_o, 32'h100);
    check("t4_inst", if_inst_o, word_at(32'h100));

    // 5: branch in the completion cycle of the word at 0x104
    step(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b1, 32'h200, 1'b1);
    check("t5_stallreq", {31'd0, stallreq_o}, 32'd1);
    check("t5_pc_kept", if_pc_o, 32'h100);
    check("t5_addr", mem_addr_o, 32'h200);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    check("t5_inst", if_inst_o, word_at(32'h200));

    // Address wrap at the top of the 32-bit space
    step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    check("wrap_inst", if_inst_o, word_at(32'hFFFF_FFFE));
    check("wrap_pc", if_pc_o, 32'hFFFF_FFFE);

    // Randomized phase
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0), tgt,
           1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a fetch with a byte in flight
    step(1'b0, 1'b1, 32'h40, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    #3 rst = 1'b1;
    #1 check_reset_values();
    mem_grant_i = 1'b0; branch_flag_i = 1'b0; mem_din_i = 8'hA5;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    check("rst_refetch_inst", if_inst_o, 32'h0000_0013);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage feeding the IF/ID pipeline register. It holds the PC and assembles each 32-bit instruction from four little-endian byte reads over the shared byte-wide memory port. It requests a pipeline stall while a word is incomplete. A branch redirect from EX aborts any in-flight fetch and restarts at the target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
ICACHE_LINES, 64, number of direct-mapped one-word cache lines (power of 2); used only with ICACHE_EN.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
stall_i  in  6  pipeline stall vector from ctrl; bit 0 = hold PC/IF
branch_flag_i  in  1  redirect request from EX
branch_target_i  in  32  redirect target PC
mem_grant_i  in  1  memory arbiter accepts this cycle's byte request
mem_din_i  in  8  read byte, valid the cycle after a granted request
mem_req_o  out  1  byte read request
mem_addr_o  out  32  byte address of request
stallreq_o  out  1  fetch incomplete, stall the pipeline
if_pc_o  out  32  PC of the word in if_inst_o
if_inst_o  out  32  assembled instruction

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, if_pc_o=RESET_PC, if_inst_o=0, mem_req_o=0, mem_addr_o=0, issue/receive counters=0, discard flag=0, state=S_FETCH. Outputs hold these values for as long as rst is high.
- States: S_FETCH (word incomplete) and S_DONE (word held). stallreq_o is combinational: stallreq_o = (state==S_FETCH).
- S_FETCH issue side:
  - While issue count iss<4: mem_req_o=1, mem_addr_o=pc+iss.
  - On each cycle with mem_grant_i=1, iss increments.
  - With mem_grant_i=0, address and request are held and iss is unchanged.
  - When iss=4, mem_req_o=0.
- S_FETCH receive side:
  - The cycle after each granted request, mem_din_i is latched into if_inst_o[8*rcv+7:8*rcv] and rcv increments.
  - Byte at pc+k maps to bits [8k+7:8k].
- Word complete: when the 4th byte is latched, state goes to S_DONE and if_pc_o=pc.
  - With continuous grant: requests in cycles 0-3, data latched at edges 1-4, stallreq_o low from cycle 5.
- S_DONE, stall_i[0]=0: pc<=pc+4, iss=rcv=0, state goes to S_FETCH. if_inst_o and if_pc_o hold their values through this edge so IF/ID captures them.
- S_DONE, stall_i[0]=1: hold everything; no memory requests.
- branch_flag_i=1 (any state; priority over stall_i and completion):
  - pc<=branch_target_i, iss=rcv=0, state goes to S_FETCH, if_inst_o<=0.
  - If a granted request is outstanding (granted in the branch cycle), the discard flag is set, so the byte returned next cycle is dropped and rcv is not advanced.
- The PC is 32-bit and wraps modulo 2^32. Byte addresses pc+k wrap likewise.
- Simultaneous completion and branch: the branch wins and the completed word is discarded.
- Reset mid-fetch: everything returns immediately to the reset values. A byte returned after reset is ignored.

Optional Feature:
ICACHE_EN
- Defined:
  - Direct-mapped cache with ICACHE_LINES lines, each holding valid, tag and a 32-bit word.
  - Index = pc[log2(ICACHE_LINES)+1:2]; tag = pc[31:log2(ICACHE_LINES)+2].
  - Entering S_FETCH checks the cache the same cycle. On a hit, if_inst_o and if_pc_o load the cached word at the next edge and state goes to S_DONE with no memory request (stallreq_o high for exactly 1 cycle).
  - On a miss, the byte fetch proceeds as normal and the completed word fills the line.
  - All valid bits clear on reset. A branch does not invalidate lines.
- Undefined: no cache storage, every word is fetched from memory, and behaviour is as in Behaviour.

Test Plan:
1. Reset release, RESET_PC=0, grant always 1, memory bytes 13,00,00,00 at 0..3 -> addresses 0,1,2,3 in cycles 0-3; stallreq_o falls in cycle 5; if_inst_o=32'h00000013, if_pc_o=0.
2. Grant low for 2 cycles during byte 2 -> mem_addr_o held at pc+2 for 3 cycles; no byte skipped; word complete 2 cycles later.
3. S_DONE with stall_i[0]=1 for 3 cycles -> no mem_req_o, outputs stable; on release pc=4 and the next fetch starts at address 4.
4. branch_flag_i=1, target 32'h100, asserted after byte 1 is granted -> stale byte discarded; next requests at 0x100..0x103; if_pc_o=32'h100 with the correct word.
5. Branch in the same cycle as completion -> completed word not presented; fetch restarts at target.
6. (ICACHE_EN) Loop branching twice to 0x40 -> first pass takes 4 memory requests; second pass has no mem_req_o and stallreq_o is high for 1 cycle only.
